// File: rtl/vec_spi_rx_pkg.sv
// Shared constants for the camera-vector SPI receiver: frame geometry,
// reset-default camera state and receiver FSM states.
package rbz_vec_pkg;

   localparam int W          = 16;
   localparam int NVEC       = 6;
   localparam int FRAME_BITS = NVEC * W;

   // Player at (5.5, 5.5) in Q6.10, facing -Y, half-width view plane along +X.
   localparam logic [15:0] PX_DEF = 16'h1600;
   localparam logic [15:0] PY_DEF = 16'h1600;
   localparam logic [15:0] FX_DEF = 16'h0000;
   localparam logic [15:0] FY_DEF = 16'hC000;
   localparam logic [15:0] VX_DEF = 16'h2000;
   localparam logic [15:0] VY_DEF = 16'h0000;

   localparam logic [95:0] FRAME_DEF = {PX_DEF, PY_DEF, FX_DEF, FY_DEF, VX_DEF, VY_DEF};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/vec_spi_rx_if.sv
// SPI pin bundle for the vectors port: the host drives it, the receiver samples it.
interface vec_spi_if;

   logic sclk;
   logic mosi;
   logic ss_n;

   modport master (output sclk, output mosi, output ss_n);
   modport slave  (input  sclk, input  mosi, input  ss_n);

endinterface

// File: rtl/vec_spi_rx_sync_edge.sv
// Three-stage synchroniser with registered rise/fall strobes; o_level is the
// third stage so a data line sampled on o_rise lines up with its clock edge.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] sync_q;
   logic       rise_q;
   logic       fall_q;

   // The chain keeps sampling through reset so a pin already low at release
   // is not mistaken for a fresh edge.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[1:0], i_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= sync_q[1] & ~sync_q[2];
         fall_q <= ~sync_q[1] & sync_q[2];
      end
   end

   assign o_level = sync_q[2];
   assign o_rise  = rise_q;
   assign o_fall  = fall_q;

endmodule

// File: rtl/vec_spi_rx.sv
// Receives a 96-bit camera-state frame over SPI, stages it, and applies all
// six vectors together on the frame-boundary strobe.
module vec_spi_rx #(
   parameter int W    = rbz_vec_pkg::W,
   parameter int NVEC = rbz_vec_pkg::NVEC
) (
   input  logic                clk,
   input  logic                reset,
   vec_spi_if.slave            spi,
   input  logic                i_load,
   output logic [W-1:0]        o_px,
   output logic [W-1:0]        o_py,
   output logic [W-1:0]        o_fx,
   output logic [W-1:0]        o_fy,
   output logic [W-1:0]        o_vx,
   output logic [W-1:0]        o_vy,
   output logic                o_pending,
   output logic                o_applied,
   output logic                o_frame_err,
   output rbz_vec_pkg::state_t o_dbg_state
);

   import rbz_vec_pkg::*;

   localparam int FB = NVEC * W;

   logic sclk_rise;
   logic sclk_fall;
   logic sclk_lvl;
   logic ss_rise;
   logic ss_fall;
   logic ss_lvl;
   logic mosi_lvl;
   logic mosi_rise;
   logic mosi_fall;

   sync_edge u_sync_sclk (
      .clk     (clk),
      .reset   (reset),
      .i_d     (spi.sclk),
      .o_level (sclk_lvl),
      .o_rise  (sclk_rise),
      .o_fall  (sclk_fall)
   );

   sync_edge u_sync_ss (
      .clk     (clk),
      .reset   (reset),
      .i_d     (spi.ss_n),
      .o_level (ss_lvl),
      .o_rise  (ss_rise),
      .o_fall  (ss_fall)
   );

   sync_edge u_sync_mosi (
      .clk     (clk),
      .reset   (reset),
      .i_d     (spi.mosi),
      .o_level (mosi_lvl),
      .o_rise  (mosi_rise),
      .o_fall  (mosi_fall)
   );

   state_t        state_q,   state_d;
   logic [6:0]    cnt_q,     cnt_d;
   logic [FB-1:0] shift_q,   shift_d;
   logic [FB-1:0] stage_q,   stage_d;
   logic [FB-1:0] out_q,     out_d;
   logic          pending_q, pending_d;
   logic          applied_q, applied_d;
   logic          err_q,     err_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      stage_d   = stage_q;
      out_d     = out_q;
      pending_d = pending_q;
      applied_d = 1'b0;
      err_d     = 1'b0;

      // Apply reads the old staging contents, so a frame completing in the
      // same cycle is kept staged for the next strobe.
      if (i_load && pending_q) begin
         out_d     = stage_q;
         pending_d = 1'b0;
         applied_d = 1'b1;
      end

      if (ss_fall) begin
         state_d = RECV;
         cnt_d   = 7'd0;
      end else if (ss_rise) begin
         if ((state_q == RECV) && (cnt_q != 7'd0)) begin
            err_d = 1'b1;
         end
         state_d = IDLE;
      end else if ((state_q == RECV) && sclk_rise) begin
         shift_d = {shift_q[FB-2:0], mosi_lvl};
         cnt_d   = cnt_q + 7'd1;
         if (cnt_q == 7'(FB - 1)) begin
            stage_d   = shift_d;
            pending_d = 1'b1;
            state_d   = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 7'd0;
         shift_q   <= '0;
         stage_q   <= FB'(FRAME_DEF);
         out_q     <= FB'(FRAME_DEF);
         pending_q <= 1'b0;
         applied_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         stage_q   <= stage_d;
         out_q     <= out_d;
         pending_q <= pending_d;
         applied_q <= applied_d;
         err_q     <= err_d;
      end
   end

   // Field order: first bit on the wire is the MSB of px.
   assign o_px        = out_q[6*W-1 -: W];
   assign o_py        = out_q[5*W-1 -: W];
   assign o_fx        = out_q[4*W-1 -: W];
   assign o_fy        = out_q[3*W-1 -: W];
   assign o_vx        = out_q[2*W-1 -: W];
   assign o_vy        = out_q[1*W-1 -: W];
   assign o_pending   = pending_q;
   assign o_applied   = applied_q;
   assign o_frame_err = err_q;
   assign o_dbg_state = state_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, sclk_lvl, sclk_fall, ss_lvl, mosi_rise, mosi_fall};

endmodule

// File: tb/tb_vec_spi_rx.sv
// Directed bench for vec_spi_rx: SPI frames driven bit by bit, checked
// against hand-written expected vectors.
module tb_vec_spi_rx;

   localparam logic [95:0] DEF = 96'h1600_1600_0000_C000_2000_0000;
   localparam logic [95:0] F1  = 96'h0400_0C00_4000_0000_0000_2000;
   localparam logic [95:0] FA  = 96'h1234_0567_3FFF_C001_1000_F000;
   localparam logic [95:0] FB  = 96'h0A00_0B00_0000_4000_E000_0000;
   localparam logic [95:0] FC  = 96'h2800_0800_2D41_D2BF_16A1_16A1;

   logic clk;
   logic reset;
   logic load;
   logic [15:0] px, py, fx, fy, vx, vy;
   logic pending, applied, frame_err;
   rbz_vec_pkg::state_t dbg_state;

   int total;
   int bad;
   int applied_seen;
   int err_seen;

   vec_spi_if spi ();

   vec_spi_rx dut (
      .clk         (clk),
      .reset       (reset),
      .spi         (spi.slave),
      .i_load      (load),
      .o_px        (px),
      .o_py        (py),
      .o_fx        (fx),
      .o_fy        (fy),
      .o_vx        (vx),
      .o_vy        (vy),
      .o_pending   (pending),
      .o_applied   (applied),
      .o_frame_err (frame_err),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (applied)   applied_seen++;
         if (frame_err) err_seen++;
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame();
      spi.ss_n = 1'b0;
      cyc(4);
   endtask

   task automatic send_bit(input logic b);
      spi.mosi = b;
      cyc(4);
      spi.sclk = 1'b1;
      cyc(4);
      spi.sclk = 1'b0;
   endtask

   task automatic end_frame();
      cyc(4);
      spi.ss_n = 1'b1;
      cyc(6);
   endtask

   task automatic send_frame(input logic [95:0] f);
      start_frame();
      for (int i = 0; i < 96; i++) send_bit(f[95-i]);
      end_frame();
   endtask

   task automatic pulse_load();
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== DEF) begin
         bad++; $display("FAIL reset_out: got %h want %h", {px, py, fx, fy, vx, vy}, DEF);
      end
      total++;
      if ({pending, applied, frame_err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {pending, applied, frame_err});
      end
      total++;
      if (dbg_state !== rbz_vec_pkg::IDLE) begin
         bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, rbz_vec_pkg::IDLE);
      end
   endtask

   task automatic test_full_frame();
      int a0, e0;
      a0 = applied_seen;
      e0 = err_seen;
      start_frame();
      for (int i = 0; i < 95; i++) send_bit(F1[95-i]);
      spi.mosi = F1[0];
      cyc(4);
      spi.sclk = 1'b1;
      cyc(3);
      @(negedge clk);
      total++;
      if (pending !== 1'b0) begin
         bad++; $display("FAIL pend_early: got %b want 0", pending);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (pending !== 1'b1) begin
         bad++; $display("FAIL pend_latency: got %b want 1", pending);
      end
      total++;
      if ({px, py, fx, fy, vx, vy} !== DEF) begin
         bad++; $display("FAIL staged_hold: got %h want %h", {px, py, fx, fy, vx, vy}, DEF);
      end
      cyc(1);
      spi.sclk = 1'b0;
      end_frame();
      pulse_load();
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== F1) begin
         bad++; $display("FAIL apply_out: got %h want %h", {px, py, fx, fy, vx, vy}, F1);
      end
      total++;
      if ({applied, pending} !== 2'b10) begin
         bad++; $display("FAIL apply_flags: got %b want 10", {applied, pending});
      end
      cyc(3);
      total++;
      if (applied_seen - a0 !== 1 || err_seen - e0 !== 0) begin
         bad++; $display("FAIL apply_pulses: applied %0d err %0d want 1 0", applied_seen - a0, err_seen - e0);
      end
   endtask

   task automatic test_short_frame();
      int a0, e0;
      a0 = applied_seen;
      e0 = err_seen;
      start_frame();
      for (int i = 0; i < 40; i++) send_bit(FA[95-i]);
      end_frame();
      total++;
      if (err_seen - e0 !== 1) begin
         bad++; $display("FAIL short_err: got %0d pulses want 1", err_seen - e0);
      end
      total++;
      if (pending !== 1'b0) begin
         bad++; $display("FAIL short_pend: got %b want 0", pending);
      end
      pulse_load();
      cyc(2);
      total++;
      if ({px, py, fx, fy, vx, vy} !== F1 || applied_seen - a0 !== 0) begin
         bad++; $display("FAIL short_load: got %h applied %0d want %h 0", {px, py, fx, fy, vx, vy}, applied_seen - a0, F1);
      end
      // select without clocks is not an error
      e0 = err_seen;
      start_frame();
      end_frame();
      total++;
      if (err_seen - e0 !== 0) begin
         bad++; $display("FAIL empty_sel: got %0d err pulses want 0", err_seen - e0);
      end
   endtask

   task automatic test_overwrite();
      send_frame(FA);
      send_frame(FB);
      total++;
      if (pending !== 1'b1) begin
         bad++; $display("FAIL ovw_pend: got %b want 1", pending);
      end
      pulse_load();
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== FB) begin
         bad++; $display("FAIL ovw_out: got %h want %h", {px, py, fx, fy, vx, vy}, FB);
      end
      total++;
      if (pending !== 1'b0) begin
         bad++; $display("FAIL ovw_clear: got %b want 0", pending);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(FA);
      start_frame();
      for (int i = 0; i < 95; i++) send_bit(FB[95-i]);
      spi.mosi = FB[0];
      cyc(4);
      spi.sclk = 1'b1;
      cyc(3);
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== FA) begin
         bad++; $display("FAIL simul_out: got %h want %h", {px, py, fx, fy, vx, vy}, FA);
      end
      total++;
      if ({pending, applied} !== 2'b11) begin
         bad++; $display("FAIL simul_flags: got %b want 11", {pending, applied});
      end
      cyc(1);
      spi.sclk = 1'b0;
      end_frame();
      pulse_load();
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== FB || pending !== 1'b0) begin
         bad++; $display("FAIL simul_next: got %h pend %b want %h 0", {px, py, fx, fy, vx, vy}, pending, FB);
      end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      logic [99:0] long_f;
      e0 = err_seen;
      start_frame();
      for (int i = 0; i < 50; i++) send_bit(FA[95-i]);
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== DEF || pending !== 1'b0) begin
         bad++; $display("FAIL midrst_out: got %h pend %b want %h 0", {px, py, fx, fy, vx, vy}, pending, DEF);
      end
      for (int i = 50; i < 96; i++) send_bit(FA[95-i]);
      end_frame();
      total++;
      if (pending !== 1'b0 || err_seen - e0 !== 0) begin
         bad++; $display("FAIL midrst_tail: pend %b err %0d want 0 0", pending, err_seen - e0);
      end
      long_f = {FC, 4'hF};
      start_frame();
      for (int i = 0; i < 100; i++) send_bit(long_f[99-i]);
      end_frame();
      total++;
      if (pending !== 1'b1 || err_seen - e0 !== 0) begin
         bad++; $display("FAIL extra_bits: pend %b err %0d want 1 0", pending, err_seen - e0);
      end
      pulse_load();
      @(negedge clk);
      total++;
      if ({px, py, fx, fy, vx, vy} !== FC) begin
         bad++; $display("FAIL extra_data: got %h want %h", {px, py, fx, fy, vx, vy}, FC);
      end
   endtask

   // sequence and report
   initial begin
      total = 0;
      bad = 0;
      applied_seen = 0;
      err_seen = 0;
      reset = 1'b1;
      load = 1'b0;
      spi.sclk = 1'b0;
      spi.mosi = 1'b0;
      spi.ss_n = 1'b1;
      cyc(4);
      test_reset();
      test_full_frame();
      test_short_frame();
      test_overwrite();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
